frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Single-port BRAM arbiter that shares the frame-buffer port between the VGA display scanner (read requester) and a pixel writer (image loader / processor write requester). The display has fixed priority, bounded by a starvation guard that forces a pending write through after `STARVE_LIMIT` consecutive lost cycles. The block owns all BRAM port signals, registers them, and returns read data to the display with a fixed, parameterised latency. It sits between the display timing generator and the BRAM Port A.

## Interface
- `ADDR_W`, 32, byte-address width of all address ports
- `DATA_W`, 32, BRAM word width; `DATA_W/8` byte enables
- `RD_LATENCY`, 2, cycles from BRAM issue to valid `bram_dout` (1 or 2 supported)
- `STARVE_LIMIT`, 8, consecutive cycles a pending write may lose before it wins
- `ADDR_LIMIT`, 147456, first illegal byte address (256*144*4)

Ports:
- `clk`  in  1  sole clock; one clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rd_req`  in  1  display read request; held with `rd_addr` until `rd_gnt`
- `rd_addr`  in  ADDR_W  display byte address, word aligned
- `rd_gnt`  out  1  combinational; read accepted this cycle
- `rd_valid`  out  1  `rd_data` valid, one pulse per granted read
- `rd_data`  out  DATA_W  read word
- `wr_valid`  in  1  writer offers a write
- `wr_ready`  out  1  holding register empty; write accepted when both high
- `wr_addr`  in  ADDR_W  writer byte address
- `wr_data`  in  DATA_W  write word
- `wr_be`  in  DATA_W/8  byte enables
- `wr_err`  out  1  sticky: an illegal write was dropped
- `rd_stall_cnt`  out  16  saturating count of cycles display lost to the guard
- `bram_en`, `bram_we` (DATA_W/8), `bram_addr` (ADDR_W), `bram_din` (DATA_W)  out  registered BRAM port
- `bram_dout`  in  DATA_W  BRAM read data

## Operation
- Write holding register: one entry. `wr_ready = !pending`. On `wr_valid && wr_ready`: if `wr_addr >= ADDR_LIMIT` or `wr_addr[1:0] != 0`, write discarded, `wr_err` set (cleared only by reset), `pending` stays 0; else addr/data/be captured, `pending = 1` next cycle. Max write throughput one per 2 cycles.
- Starve counter `sc` (width clog2(STARVE_LIMIT)+1): increments each cycle `pending && rd_req` and the read wins; cleared when the write is granted or `pending == 0`.
- Per-cycle decision (combinational): `grant_wr = pending && (!rd_req || sc == STARVE_LIMIT)`; `grant_rd = rd_req && !grant_wr`; `rd_gnt = grant_rd`.
- Issue (registered, next edge): grant_rd -> `bram_en=1`, `bram_we=0`, `bram_addr=rd_addr`. grant_wr -> `bram_en=1`, `bram_we=wr_be_q`, `bram_addr=wr_addr_q`, `bram_din=wr_data_q`, `pending` cleared. Neither -> `bram_en=0`, `bram_we=0`, addr/din hold.
- Reads never enter the holding register; read addresses are not range-checked (display is trusted).
- Read return: RD_LATENCY-deep valid shift register loaded with the read-issue bit; `rd_valid` = last stage; `rd_data = bram_dout` (passthrough, X-free when `rd_valid=0` not required).
- `rd_stall_cnt` increments when `rd_req && pending && sc == STARVE_LIMIT`; saturates at 0xFFFF.

## Timing
- Reset values: `bram_en=0`, `bram_we=0`, `bram_addr=0`, `bram_din=0`, `rd_valid=0`, `wr_err=0`, `rd_stall_cnt=0`, `pending=0` (so `wr_ready=1`), `sc=0`.
- Read: `rd_gnt` in cycle N -> `bram_en` cycle N+1 -> `rd_valid` cycle N+1+RD_LATENCY.
- Write: accepted cycle N -> earliest issue cycle N+2 (`pending` visible N+1, granted N+1 if no read/guard hit).
- Simultaneous `rd_req` and pending write: read wins unless `sc == STARVE_LIMIT`; on guard cycle `rd_gnt=0`, display holds request, served next cycle.
- Back-to-back reads: one grant per cycle, issues pipelined, `rd_valid` contiguous.
- Reset mid-operation: pending write lost, valid pipe flushed (no `rd_valid` after reset for pre-reset grants), BRAM port idle.

## Test plan
- Reset then idle: all outputs at reset values, `wr_ready=1`, no `bram_en` for 20 cycles.
- Single read `rd_addr=0x40`, BRAM preloaded 0xDEADBEEF at word 16 -> `rd_gnt` cycle N, `bram_addr=0x40` N+1, `rd_valid` with 0xDEADBEEF at N+3 (RD_LATENCY=2).
- Write `0x100`/0x12345678/be=0xF with `rd_req=0` -> `bram_we=0xF`, `bram_addr=0x100` two cycles after accept; readback returns 0x12345678.
- Continuous `rd_req` plus one write -> write issued exactly after 8 read grants (guard), one cycle with `rd_gnt=0`, `rd_stall_cnt=1`, no read lost or duplicated.
- Write to `0x24000` and to `0x102` -> both dropped, no `bram_we`, `wr_err=1` persists until reset.
- Assert `reset` one cycle after a read grant with write pending -> no `rd_valid`, no `bram_we`, all outputs at reset values.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Arbitrates the single frame-buffer BRAM port between display reads and pixel writes.
// Reads have fixed priority. A starvation guard forces a pending write through.
module frame_buffer_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_LIMIT   = 147456
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_gnt,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_err,
  output logic [15:0]         rd_stall_cnt,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout
);
  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(STARVE_LIMIT) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wr_req_t;

  wr_req_t             wr_q;
  logic                pending;
  logic [SC_W-1:0]     sc;
  logic [RD_LATENCY:0] vld_pipe;
  logic                guard_hit, grant_wr, grant_rd, wr_accept, wr_legal;

  assign guard_hit = pending && (sc == SC_W'(STARVE_LIMIT));
  assign grant_wr  = pending && (!rd_req || guard_hit);
  assign grant_rd  = rd_req && !grant_wr;
  assign rd_gnt    = grant_rd;
  assign wr_ready  = !pending;
  assign wr_accept = wr_valid && !pending;
  assign wr_legal  = (wr_addr < ADDR_W'(ADDR_LIMIT)) && (wr_addr[1:0] == 2'b00);

  // Single-entry holding register; illegal writes are dropped at the door.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      wr_q    <= '0;
      wr_err  <= 1'b0;
    end else begin
      if (wr_accept && wr_legal) begin
        pending <= 1'b1;
        wr_q    <= '{addr: wr_addr, data: wr_data, be: wr_be};
      end else if (grant_wr) begin
        pending <= 1'b0;
      end
      if (wr_accept && !wr_legal) wr_err <= 1'b1;
    end
  end

  // Counts reads that won while a write waited; never exceeds the limit
  // because reaching it hands the next cycle to the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     sc <= '0;
    else if (!pending || grant_wr) sc <= '0;
    else if (grant_rd)             sc <= sc + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_stall_cnt <= '0;
    else if (rd_req && guard_hit && rd_stall_cnt != 16'hFFFF)
      rd_stall_cnt <= rd_stall_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram_en   <= 1'b0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else if (grant_rd) begin
      bram_en   <= 1'b1;
      bram_we   <= '0;
      bram_addr <= rd_addr;
    end else if (grant_wr) begin
      bram_en   <= 1'b1;
      bram_we   <= wr_q.be;
      bram_addr <= wr_q.addr;
      bram_din  <= wr_q.data;
    end else begin
      bram_en   <= 1'b0;
      bram_we   <= '0;
    end
  end

  // Stage 0 is the issue cycle; stage RD_LATENCY lines up with bram_dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[RD_LATENCY-1:0], grant_rd};
  end

  assign rd_valid = vld_pipe[RD_LATENCY];
  assign rd_data  = bram_dout;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: BRAM model, read-data scoreboard, write-vector table
// and hand sequences for latency, starvation guard and mid-operation reset.
module tb_frame_buffer_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_gnt, rd_valid;
  logic [31:0] rd_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        wr_err;
  logic [15:0] rd_stall_cnt;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_din, bram_dout;

  frame_buffer_arbiter dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_err(wr_err), .rd_stall_cnt(rd_stall_cnt),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Two-stage read BRAM model, preloaded on the first edge.
  logic [31:0] mem [65536];
  logic [31:0] s1;
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    logic [31:0] w;
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : {16'hC0DE, i[15:0]};
      mem_init <= 1'b1;
    end else if (bram_en) begin
      if (bram_we == 4'h0) s1 <= mem[bram_addr[17:2]];
      else begin
        w = mem[bram_addr[17:2]];
        for (int b = 0; b < 4; b++) if (bram_we[b]) w[8*b +: 8] = bram_din[8*b +: 8];
        mem[bram_addr[17:2]] <= w;
      end
    end
    bram_dout <= s1;
  end

  // Independent expected memory contents.
  logic [31:0] shadow [65536];
  function automatic void upd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) shadow[a[17:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Scoreboard: expected word queued at grant, popped at rd_valid.
  logic [31:0] sb_q [$];
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) sb_q.delete();
    else begin
      if (rd_gnt) sb_q.push_back(shadow[rd_addr[17:2]]);
      if (rd_valid) begin
        if (sb_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rd_req = 0; wr_valid = 0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bram_en", bram_en, 0);     chk("rst_bram_we", bram_we, 0);
    chk("rst_bram_addr", bram_addr, 0); chk("rst_bram_din", bram_din, 0);
    chk("rst_rd_valid", rd_valid, 0);   chk("rst_wr_err", wr_err, 0);
    chk("rst_stall", rd_stall_cnt, 0);  chk("rst_wr_ready", wr_ready, 1);
    @(posedge clk); #1; reset = 0;
  endtask

  task automatic do_read(input logic [31:0] a);
    bit got = 0;
    rd_req = 1; rd_addr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_gnt) begin got = 1; break; end
      cyc();
    end
    if (!got) chk("rd_gnt_timeout", 0, 1);
    cyc(); rd_req = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
    chk("sb_drain", sb_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          legal;
  } wvec_t;
  wvec_t wv [6];

  int n_pg;
  bit guard, g;

  initial begin
    for (int i = 0; i < 65536; i++) shadow[i] = (i == 16) ? 32'hDEADBEEF : {16'hC0DE, i[15:0]};
    wv[0] = '{32'h0000_0100, 32'h1234_5678, 4'hF, 1'b1};
    wv[1] = '{32'h0002_4000, 32'hBAD0_BAD0, 4'hF, 1'b0};
    wv[2] = '{32'h0000_0102, 32'hBAD1_BAD1, 4'hF, 1'b0};
    wv[3] = '{32'h0002_3FFC, 32'hCAFE_F00D, 4'hF, 1'b1};
    wv[4] = '{32'h0000_0080, 32'h1122_33AA, 4'h5, 1'b1};
    wv[5] = '{32'hFFFF_FFFC, 32'hBAD2_BAD2, 4'hF, 1'b0};

    // Reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_bram_en", bram_en, 0);
      cyc();
    end

    // Single read: grant N, issue N+1, data N+3
    rd_req = 1; rd_addr = 32'h40;
    @(negedge clk); chk("rd1_gnt", rd_gnt, 1);
    cyc(); rd_req = 0;
    @(negedge clk);
    chk("rd1_bram_en", bram_en, 1); chk("rd1_bram_addr", bram_addr, 32'h40);
    chk("rd1_bram_we", bram_we, 0); chk("rd1_valid_n1", rd_valid, 0);
    cyc(); @(negedge clk); chk("rd1_valid_n2", rd_valid, 0);
    cyc(); @(negedge clk); chk("rd1_valid_n3", rd_valid, 1); chk("rd1_data", rd_data, 32'hDEADBEEF);
    cyc(); drain();

    // Write vectors: legality, issue timing, sticky error, readback
    foreach (wv[i]) begin
      do_reset();
      wr_valid = 1; wr_addr = wv[i].addr; wr_data = wv[i].data; wr_be = wv[i].be;
      if (wv[i].legal) upd(wv[i].addr, wv[i].data, wv[i].be);
      @(negedge clk); chk("wr_accept", wr_ready, 1);
      cyc(); wr_valid = 0;
      @(negedge clk); chk("wr_pending", wr_ready, !wv[i].legal); chk("wr_no_early", bram_en, 0);
      cyc(); @(negedge clk);
      chk("wr_issue_we", bram_we, wv[i].legal ? wv[i].be : 4'h0);
      if (wv[i].legal) begin
        chk("wr_issue_addr", bram_addr, wv[i].addr);
        chk("wr_issue_din", bram_din, wv[i].data);
      end
      chk("wr_err", wr_err, !wv[i].legal);
      repeat (4) cyc();
      chk("wr_err_sticky", wr_err, !wv[i].legal);
      if (wv[i].legal) begin
        do_read(wv[i].addr);
        drain();
      end
    end

    // Starvation guard under continuous reads
    do_reset();
    rd_req = 1; rd_addr = 32'h200;
    wr_valid = 1; wr_addr = 32'h1000; wr_data = 32'h600DF00D; wr_be = 4'hF;
    upd(32'h1000, 32'h600DF00D, 4'hF);
    @(negedge clk); chk("gd_accept", wr_ready, 1); chk("gd_first_gnt", rd_gnt, 1);
    cyc(); wr_valid = 0; rd_addr = 32'h204;
    n_pg = 0; guard = 0;
    for (int c = 0; c < 16 && !guard; c++) begin
      @(negedge clk);
      g = rd_gnt;
      if (!wr_ready && !rd_gnt) guard = 1;
      else if (!wr_ready && rd_gnt) n_pg++;
      cyc();
      if (g) rd_addr = rd_addr + 32'd4;
    end
    chk("gd_found", guard, 1);
    chk("gd_grants_before", n_pg, 8);
    @(negedge clk);
    chk("gd_bram_we", bram_we, 4'hF); chk("gd_bram_addr", bram_addr, 32'h1000);
    chk("gd_bram_din", bram_din, 32'h600DF00D); chk("gd_stall", rd_stall_cnt, 1);
    chk("gd_held_served", rd_gnt, 1);
    cyc(); rd_req = 0;
    drain();
    do_read(32'h1000);
    drain();

    // Reset one cycle after a read grant with a write pending
    do_reset();
    rd_req = 1; rd_addr = 32'h300;
    wr_valid = 1; wr_addr = 32'h400; wr_data = 32'hFEEDFACE; wr_be = 4'hF;
    cyc(); wr_valid = 0; rd_addr = 32'h304;
    @(negedge clk); chk("mr_gnt", rd_gnt, 1); chk("mr_pending", wr_ready, 0);
    cyc(); reset = 1; rd_req = 0;
    @(negedge clk);
    chk("mr_bram_en", bram_en, 0);     chk("mr_bram_we", bram_we, 0);
    chk("mr_bram_addr", bram_addr, 0); chk("mr_bram_din", bram_din, 0);
    chk("mr_rd_valid", rd_valid, 0);   chk("mr_wr_ready", wr_ready, 1);
    chk("mr_wr_err", wr_err, 0);       chk("mr_stall", rd_stall_cnt, 0);
    cyc(); reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_idle_en", bram_en, 0); chk("mr_idle_we", bram_we, 0); chk("mr_idle_valid", rd_valid, 0);
      cyc();
    end
    do_read(32'h400);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
